config_loader: RTL
==================

CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: one-cycle request to begin or restart a configuration load.
REQ-004 SHALL have port in_data, input, 8 bits: bitstream byte.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: loader can accept a byte; a byte transfers in any cycle with in_valid=1 and in_ready=1.
REQ-007 SHALL have port cfg_addr, output, 5 bits: target number; 0-10 are switch boxes, 11-21 are logic tiles.
REQ-008 SHALL have port cfg_data, output, 33 bits: configuration word for the target.
REQ-009 SHALL have port cfg_we, output, 1 bit: one-cycle write strobe for cfg_addr/cfg_data.
REQ-010 SHALL have port fabric_enable, output, 1 bit: fabric configured and allowed to run.
REQ-011 SHALL have port done, output, 1 bit: load finished with a good checksum.
REQ-012 SHALL have port error, output, 1 bit: checksum mismatch.
REQ-013 SHALL have port state, output, 3 bits: IDLE=0, SYNC=1, LOAD=2, CHECK=3, DONE=4, ERROR=5.

Function
REQ-014 SHALL implement states IDLE, SYNC, LOAD, CHECK, DONE and ERROR, with in_ready=1 only in SYNC, LOAD and CHECK.
REQ-015 SHALL move from IDLE to SYNC on start=1, clearing byte counters, target counter and checksum.
REQ-016 SHALL compare each accepted byte in SYNC against 0xA5: on a match go to LOAD; otherwise stay in SYNC and discard the byte (hunt mode).
REQ-017 SHALL treat the bitstream as 22 frames in target order 0..21, LSB byte first: targets 0-10 take 2 bytes (16 bits) and targets 11-21 take 5 bytes, of which the low 33 bits are used and in_data[7:1] of the fifth byte is ignored.
REQ-018 SHALL, in the cycle after the last byte of a frame is accepted, assert cfg_we=1 for exactly one cycle with cfg_addr set to the target and cfg_data set to the frame; switch-box frames SHALL be zero-extended to 33 bits.
REQ-019 SHALL hold cfg_addr and cfg_data stable between writes.
REQ-020 SHALL keep in_ready=1 during the cfg_we cycle, so back-to-back bytes are never stalled.
REQ-021 SHALL XOR all 77 payload bytes into an 8-bit checksum; the sync byte is excluded.
REQ-022 SHALL go from LOAD to CHECK after the byte that completes target 21 is accepted.
REQ-023 SHALL, in CHECK, compare the accepted byte with the checksum: on a match go to DONE, otherwise go to ERROR.
REQ-024 SHALL, in DONE, hold done=1 and fabric_enable=1; in ERROR it SHALL hold error=1 and fabric_enable=0.
REQ-025 SHALL, on start=1 in DONE or ERROR, go to SYNC and clear done, error, fabric_enable, counters and checksum in that same transition.
REQ-026 SHALL ignore start=1 in SYNC, LOAD or CHECK.
REQ-027 SHALL make no state or counter change when in_valid=0, and SHALL treat stalls of any length as transparent.
REQ-028 SHALL hold fabric_enable=0 in every state except DONE.

Reset
REQ-029 SHALL, when reset=1 at a clock edge, enter IDLE and clear in_ready, cfg_we, cfg_addr, cfg_data, fabric_enable, done, error, checksum and all counters to 0, regardless of state.
REQ-030 SHALL give reset priority over start and in_valid in the same cycle, and SHALL write no partial frame after reset.

Verification
REQ-031 SHALL pass the scenario: reset, start, 0xA5, then 77 bytes of 0x00 and checksum 0x00 -> 22 cfg_we pulses with addresses 0..21 and data 0, then state=4, done=1 and fabric_enable=1.
REQ-032 SHALL pass the scenario: same stream but target 11 bytes 0xFF,0xFF,0xFF,0xFF,0x01 and checksum 0x01 -> write for cfg_addr=11 has cfg_data=0x1_FFFF_FFFF, then DONE.
REQ-033 SHALL pass the scenario: a good stream with checksum byte 0x5A (correct 0x00) -> state=5, error=1, fabric_enable=0, in_ready=0.
REQ-034 SHALL pass the scenario: 0x12, 0x34 then 0xA5 in SYNC -> first two bytes are discarded, LOAD is entered only after 0xA5, and there is no cfg_we before the first frame completes.
REQ-035 SHALL pass the scenario: reset asserted after target 5 is written and mid-frame of target 6 -> next cycle state=0 and all outputs are 0; a fresh start plus full stream completes normally.
REQ-036 SHALL pass the scenario: random in_valid gaps of 0-5 cycles during a good stream, and start pulses while in LOAD -> results identical to the gap-free run, with start ignored.

Source files
------------

// File: rtl/config_loader.sv
// Configuration loader: hunts for a 0xA5 sync byte, unpacks 22 frames into
// per-target configuration writes, then verifies an XOR checksum byte before
// enabling the fabric.
module config_loader (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [4:0]  cfg_addr,
    output logic [32:0] cfg_data,
    output logic        cfg_we,
    output logic        fabric_enable,
    output logic        done,
    output logic        error,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSync  = 3'd1,
        StLoad  = 3'd2,
        StCheck = 3'd3,
        StDone  = 3'd4,
        StError = 3'd5
    } state_e;

    localparam logic [7:0] SyncByte   = 8'hA5;
    localparam logic [4:0] FirstTile  = 5'd11;
    localparam logic [4:0] LastTarget = 5'd21;

    state_e      state_q;
    logic [2:0]  byte_cnt_q;
    logic [4:0]  target_q;
    logic [32:0] frame_q;
    logic [7:0]  checksum_q;

    logic        accept;
    logic        last_byte;
    logic [32:0] frame_next;

    assign accept = in_valid & in_ready;
    assign state  = state_q;

    // Merge the incoming byte into the partially assembled frame
    always_comb begin
        last_byte  = (target_q < FirstTile) ? (byte_cnt_q == 3'd1) : (byte_cnt_q == 3'd4);
        frame_next = frame_q;
        case (byte_cnt_q)
            3'd0:    frame_next[7:0]   = in_data;
            3'd1:    frame_next[15:8]  = in_data;
            3'd2:    frame_next[23:16] = in_data;
            3'd3:    frame_next[31:24] = in_data;
            // Fifth byte of a logic-tile frame contributes only bit 32
            default: frame_next[32]    = in_data[0];
        endcase
    end

    // Loader FSM with registered handshake, write strobe and status outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            byte_cnt_q    <= 3'd0;
            target_q      <= 5'd0;
            frame_q       <= 33'd0;
            checksum_q    <= 8'd0;
            in_ready      <= 1'b0;
            cfg_we        <= 1'b0;
            cfg_addr      <= 5'd0;
            cfg_data      <= 33'd0;
            fabric_enable <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            cfg_we <= 1'b0;
            unique case (state_q)
                StIdle, StDone, StError: begin
                    if (start) begin
                        state_q       <= StSync;
                        byte_cnt_q    <= 3'd0;
                        target_q      <= 5'd0;
                        frame_q       <= 33'd0;
                        checksum_q    <= 8'd0;
                        in_ready      <= 1'b1;
                        fabric_enable <= 1'b0;
                        done          <= 1'b0;
                        error         <= 1'b0;
                    end
                end
                StSync: begin
                    // Non-sync bytes are simply dropped while hunting
                    if (accept && in_data == SyncByte) begin
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    if (accept) begin
                        checksum_q <= checksum_q ^ in_data;
                        if (last_byte) begin
                            cfg_we     <= 1'b1;
                            cfg_addr   <= target_q;
                            cfg_data   <= frame_next;
                            // Clearing here keeps 2-byte frames zero-extended
                            frame_q    <= 33'd0;
                            byte_cnt_q <= 3'd0;
                            if (target_q == LastTarget) begin
                                state_q <= StCheck;
                            end else begin
                                target_q <= target_q + 5'd1;
                            end
                        end else begin
                            frame_q    <= frame_next;
                            byte_cnt_q <= byte_cnt_q + 3'd1;
                        end
                    end
                end
                StCheck: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (in_data == checksum_q) begin
                            state_q       <= StDone;
                            done          <= 1'b1;
                            fabric_enable <= 1'b1;
                        end else begin
                            state_q <= StError;
                            error   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
